// File: rtl/bram_fetch_pkg.sv
// rtl/bram_fetch_pkg.sv - shared state, mode, tag types and helpers for the BRAM weight fetcher
package bram_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE,
        FLUSH
    } fetch_state_t;

    localparam logic MODE_A_ONLY = 1'b0;
    localparam logic MODE_SPLIT  = 1'b1;

    typedef struct packed {
        logic valid;
        logic port_sel;
        logic last;
    } tag_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/weight_sync_fifo.sv
// rtl/weight_sync_fifo.sv - first-word-fall-through sync FIFO with flush and occupancy count
module weight_sync_fifo
    import bram_fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // flush wins over a same-cycle write so aborted data never lands
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= bump(wr_ptr);
            if (do_rd) rd_ptr <= bump(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_weight_fetcher.sv
// rtl/bram_weight_fetcher.sv - streams a commanded burst of weight words from a dual-port BRAM to the MAC array
module bram_weight_fetcher
    import bram_fetch_pkg::*;
#(
    parameter int MAC_NUM            = 256,
    parameter int WEIGHT_WIDTH       = 5,
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int BRAM_LATENCY       = 2,
    parameter int LEN_WIDTH          = 13,
    parameter int FIFO_DEPTH         = BRAM_LATENCY + 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [BRAM_ADDRESS_WIDTH-1:0]         cmd_base_addr,
    input  logic [LEN_WIDTH-1:0]                  cmd_length,
    input  logic                                  cmd_mode,
    input  logic                                  abort,
    output logic [BRAM_ADDRESS_WIDTH-1:0]         bram_address_A,
    output logic                                  bram_A_en,
    input  logic [WEIGHT_WIDTH*MAC_NUM-1:0]       weight_from_bram_A,
    output logic [BRAM_ADDRESS_WIDTH-1:0]         bram_address_B,
    output logic                                  bram_B_en,
    input  logic [WEIGHT_WIDTH*MAC_NUM-1:0]       weight_from_bram_B,
    output logic [WEIGHT_WIDTH*MAC_NUM-1:0]       weight_out,
    output logic                                  weight_valid,
    input  logic                                  weight_ready,
    output logic                                  weight_last,
    output logic                                  busy
);

    localparam int W   = WEIGHT_WIDTH * MAC_NUM;
    localparam int AW  = BRAM_ADDRESS_WIDTH;
    localparam int FCW = clog2(FIFO_DEPTH + 1);
    localparam int SW  = clog2(2 * FIFO_DEPTH + 2) + 1;
    localparam int FLW = (BRAM_LATENCY > 1) ? clog2(BRAM_LATENCY) : 1;

    fetch_state_t         state;
    logic [AW-1:0]        base_addr;
    logic [LEN_WIDTH-1:0] length;
    logic [LEN_WIDTH-1:0] issue_idx;
    logic                 mode;
    logic                 issue_sel;
    logic                 issue_last;
    logic [FLW-1:0]       flush_cnt;
    tag_t                 tag_pipe [BRAM_LATENCY];

    tag_t                 tag_exit;
    logic [FCW-1:0]       fifo_count;
    logic                 fifo_empty;
    logic [W:0]           fifo_head;
    logic                 pop;
    logic                 abort_fire;
    logic [SW-1:0]        in_flight;
    logic [SW-1:0]        credit_use;
    logic                 can_issue;
    logic                 idx_odd;
    logic                 last_issue;
    logic [LEN_WIDTH-1:0] word_off;
    logic [AW+LEN_WIDTH-1:0] off_ext;
    logic [AW-1:0]        next_addr;

    assign tag_exit   = tag_pipe[BRAM_LATENCY-1];
    assign abort_fire = abort && (state != IDLE);
    assign pop        = !fifo_empty && weight_ready;

    always_comb begin
        in_flight = SW'(bram_A_en | bram_B_en);
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            in_flight = in_flight + SW'(tag_pipe[i].valid);
        end
    end

    // a word popped this cycle frees its slot in time for a read issued now
    assign credit_use = in_flight + SW'(fifo_count) - SW'(pop);
    assign can_issue  = credit_use < SW'(FIFO_DEPTH);

    assign idx_odd    = (mode == MODE_SPLIT) && issue_idx[0];
    assign word_off   = (mode == MODE_A_ONLY) ? issue_idx : (issue_idx >> 1);
    assign off_ext    = {{AW{1'b0}}, word_off};
    assign next_addr  = base_addr + off_ext[AW-1:0];
    assign last_issue = (issue_idx == length - LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            base_addr      <= '0;
            length         <= '0;
            mode           <= MODE_A_ONLY;
            issue_idx      <= '0;
            issue_sel      <= 1'b0;
            issue_last     <= 1'b0;
            flush_cnt      <= '0;
            bram_A_en      <= 1'b0;
            bram_B_en      <= 1'b0;
            bram_address_A <= '0;
            bram_address_B <= '0;
        end else begin
            bram_A_en <= 1'b0;
            bram_B_en <= 1'b0;
            if (abort_fire) begin
                state     <= FLUSH;
                flush_cnt <= FLW'(BRAM_LATENCY - 1);
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            base_addr <= cmd_base_addr;
                            length    <= cmd_length;
                            mode      <= cmd_mode;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            if (cmd_length == '0) begin
                                issue_idx <= '0;
                                state     <= DONE;
                            end else begin
                                // word 0 always comes from port A at the base address
                                bram_A_en      <= 1'b1;
                                bram_address_A <= cmd_base_addr;
                                issue_sel      <= 1'b0;
                                issue_last     <= (cmd_length == LEN_WIDTH'(1));
                                issue_idx      <= LEN_WIDTH'(1);
                                state          <= (cmd_length == LEN_WIDTH'(1)) ? DRAIN : ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        if (can_issue) begin
                            if (idx_odd) begin
                                bram_B_en      <= 1'b1;
                                bram_address_B <= next_addr;
                            end else begin
                                bram_A_en      <= 1'b1;
                                bram_address_A <= next_addr;
                            end
                            issue_sel  <= idx_odd;
                            issue_last <= last_issue;
                            issue_idx  <= issue_idx + LEN_WIDTH'(1);
                            if (last_issue) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if ((in_flight == '0) && fifo_empty) state <= DONE;
                    end
                    DONE: begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                    FLUSH: begin
                        if (flush_cnt == '0) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt - FLW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // tags follow the registered enables so the exit lines up with valid BRAM dout
    always_ff @(posedge clk) begin
        if (rst || abort_fire) begin
            for (int i = 0; i < BRAM_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= {bram_A_en | bram_B_en, issue_sel, issue_last};
            for (int i = 1; i < BRAM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    weight_sync_fifo #(
        .WIDTH (W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort_fire),
        .wr_en   (tag_exit.valid),
        .wr_data ({tag_exit.last, tag_exit.port_sel ? weight_from_bram_B : weight_from_bram_A}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign weight_valid = !fifo_empty;
    assign weight_out   = weight_valid ? fifo_head[W-1:0] : '0;
    assign weight_last  = weight_valid && fifo_head[W];

endmodule

// File: tb/tb_bram_weight_fetcher.sv
// tb/tb_bram_weight_fetcher.sv - directed and randomized bench for bram_weight_fetcher with a queue model
module tb_bram_weight_fetcher;

    localparam int MAC_NUM = 4;
    localparam int WW      = 8;
    localparam int W       = MAC_NUM * WW;
    localparam int AW      = 12;
    localparam int LAT     = 2;
    localparam int LW      = 13;

    typedef logic [W:0] word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base_addr = '0;
    logic [LW-1:0] cmd_length = '0;
    logic          cmd_mode = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] bram_address_A, bram_address_B;
    logic          bram_A_en, bram_B_en;
    logic [W-1:0]  weight_from_bram_A, weight_from_bram_B;
    logic [W-1:0]  weight_out;
    logic          weight_valid;
    logic          weight_ready = 1'b0;
    logic          weight_last;
    logic          busy;

    always #5 clk = ~clk;

    bram_weight_fetcher #(
        .MAC_NUM            (MAC_NUM),
        .WEIGHT_WIDTH       (WW),
        .BRAM_ADDRESS_WIDTH (AW),
        .BRAM_LATENCY       (LAT),
        .LEN_WIDTH          (LW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_base_addr      (cmd_base_addr),
        .cmd_length         (cmd_length),
        .cmd_mode           (cmd_mode),
        .abort              (abort),
        .bram_address_A     (bram_address_A),
        .bram_A_en          (bram_A_en),
        .weight_from_bram_A (weight_from_bram_A),
        .bram_address_B     (bram_address_B),
        .bram_B_en          (bram_B_en),
        .weight_from_bram_B (weight_from_bram_B),
        .weight_out         (weight_out),
        .weight_valid       (weight_valid),
        .weight_ready       (weight_ready),
        .weight_last        (weight_last),
        .busy               (busy)
    );

    logic [W-1:0]  mem_a [4096];
    logic [W-1:0]  mem_b [4096];
    logic [AW-1:0] pa [LAT];
    logic [AW-1:0] pb [LAT];

    always @(posedge clk) begin
        pa[0] <= bram_address_A;
        pb[0] <= bram_address_B;
        for (int i = 1; i < LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign weight_from_bram_A = mem_a[pa[LAT-1]];
    assign weight_from_bram_B = mem_b[pb[LAT-1]];

    int total = 0;
    int bad = 0;
    word_t         out_q[$], exp_q[$];
    logic [AW-1:0] a_q[$], b_q[$], expa_q[$], expb_q[$];
    int            a_nc[$], pop_nc[$];
    int            nc = 0, acc_nc = 0, first_valid_nc = -1, valid_cnt = 0, last_cnt = 0;
    bit            overflow = 0, stall_err = 0, prev_stall = 0;
    word_t         prev_word;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: observe at the falling edge, return just after the rising edge
    task automatic tick();
        @(negedge clk);
        nc++;
        if (cmd_valid && cmd_ready && !rst) begin
            acc_nc = nc + 1;
            first_valid_nc = -1;
        end
        if (weight_valid) begin
            valid_cnt++;
            if (first_valid_nc < 0) first_valid_nc = nc;
        end
        if (weight_valid && weight_ready) begin
            out_q.push_back({weight_last, weight_out});
            pop_nc.push_back(nc);
            if (weight_last) last_cnt++;
        end
        if (bram_A_en) begin
            a_q.push_back(bram_address_A);
            a_nc.push_back(nc);
        end
        if (bram_B_en) b_q.push_back(bram_address_B);
        if (dut.u_fifo.wr_en && dut.u_fifo.full) overflow = 1;
        if (prev_stall && (!weight_valid || ({weight_last, weight_out} !== prev_word))) stall_err = 1;
        prev_stall = weight_valid && !weight_ready && !abort && !rst;
        prev_word  = {weight_last, weight_out};
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        out_q.delete(); a_q.delete(); b_q.delete(); a_nc.delete(); pop_nc.delete();
        valid_cnt = 0; last_cnt = 0; first_valid_nc = -1;
    endtask

    task automatic send(input logic [AW-1:0] b, input int len, input bit m);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        chk(w < 50, 1, "cmd_ready_wait");
        cmd_base_addr = b;
        cmd_length    = LW'(len);
        cmd_mode      = m;
        cmd_valid     = 1'b1;
        tick();
        cmd_valid     = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input int pol);
        int c;
        c = 0;
        while (c < maxc) begin
            case (pol)
                0:       weight_ready = 1'b1;
                1:       weight_ready = (nc % 3 == 0);
                default: weight_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            if (cmd_ready) break;
            c++;
        end
        chk(c < maxc, 1, "idle_timeout");
    endtask

    task automatic model(input logic [AW-1:0] base, input int len, input bit m);
        logic [AW-1:0] ad;
        exp_q.delete(); expa_q.delete(); expb_q.delete();
        for (int k = 0; k < len; k++) begin
            ad = base + AW'(m ? k / 2 : k);
            if (!m || (k % 2 == 0)) begin
                expa_q.push_back(ad);
                exp_q.push_back({k == len - 1, mem_a[ad]});
            end else begin
                expb_q.push_back(ad);
                exp_q.push_back({k == len - 1, mem_b[ad]});
            end
        end
    endtask

    task automatic compare(input string tag, input int nwords);
        word_t o;
        chk(out_q.size(), nwords, {tag, "_count"});
        for (int i = 0; i < nwords; i++) begin
            o = (i < out_q.size()) ? out_q[i] : '1;
            chk(o, exp_q[i], $sformatf("%s_w%0d", tag, i));
        end
        if (nwords == exp_q.size()) begin
            chk(a_q.size(), expa_q.size(), {tag, "_a_cnt"});
            chk(b_q.size(), expb_q.size(), {tag, "_b_cnt"});
            for (int i = 0; i < expa_q.size() && i < a_q.size(); i++)
                chk(a_q[i], expa_q[i], $sformatf("%s_a%0d", tag, i));
            for (int i = 0; i < expb_q.size() && i < b_q.size(); i++)
                chk(b_q[i], expb_q[i], $sformatf("%s_b%0d", tag, i));
        end
    endtask

    initial begin
        logic [AW-1:0] rb;
        int            rl;
        bit            rm;

        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = W'(i);
            mem_b[i] = ~W'(i);
        end
        repeat (3) tick();
        chk(cmd_ready, 1, "rst_cmd_ready");
        chk(busy, 0, "rst_busy");
        chk(weight_valid, 0, "rst_valid");
        chk({bram_A_en, bram_B_en}, 0, "rst_en");
        rst = 1'b0;
        tick();

        // mode 0, word = address
        clear();
        send(12'h010, 4, 1'b0);
        wait_idle(100, 0);
        model(12'h010, 4, 1'b0);
        compare("t2", 4);
        chk(first_valid_nc - acc_nc, LAT + 1, "t2_latency");
        chk(a_nc.size() == 4 ? a_nc[3] - a_nc[0] : -1, 3, "t2_issue_b2b");
        chk(pop_nc.size() == 4 ? pop_nc[3] - pop_nc[0] : -1, 3, "t2_out_b2b");
        chk(out_q.size() > 3 ? out_q[3] : '0, {1'b1, 32'h13}, "t2_last_word");
        chk(last_cnt, 1, "t2_last_cnt");

        // mode 1 even/odd split
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = W'(32'h1000 + i);
            mem_b[i] = W'(32'h2000 + i);
        end
        clear();
        send(12'h020, 5, 1'b1);
        wait_idle(100, 0);
        model(12'h020, 5, 1'b1);
        compare("t3", 5);
        chk(out_q.size() > 4 ? out_q[1] : '0, {1'b0, 32'h2020}, "t3_word1");
        chk(out_q.size() > 4 ? out_q[4] : '0, {1'b1, 32'h1022}, "t3_word4");
        chk(b_q.size(), 2, "t3_b_en_cnt");

        // backpressure 1-in-3
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = W'($urandom);
            mem_b[i] = W'($urandom);
        end
        clear();
        overflow = 0; stall_err = 0;
        send(12'h300, 16, 1'b0);
        wait_idle(300, 1);
        model(12'h300, 16, 1'b0);
        compare("t4", 16);
        chk(overflow, 0, "t4_overflow");
        chk(stall_err, 0, "t4_stall_stable");

        // address wrap
        clear();
        send(12'hFFE, 4, 1'b0);
        wait_idle(100, 0);
        model(12'hFFE, 4, 1'b0);
        compare("t5", 4);
        chk(a_q.size() > 2 ? a_q[2] : '1, 12'h000, "t5_wrap_addr");

        // zero length
        clear();
        send(12'h040, 0, 1'b0);
        chk(busy, 1, "t6_len0_busy");
        tick();
        chk(busy, 0, "t6_len0_busy_fall");
        repeat (4) tick();
        chk(valid_cnt, 0, "t6_len0_no_valid");
        chk(a_q.size() + b_q.size(), 0, "t6_len0_no_en");

        // abort after 3 of 10 words
        clear();
        weight_ready = 1'b1;
        send(12'h100, 10, 1'b0);
        for (int c = 0; c < 100 && out_q.size() < 3; c++) tick();
        weight_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk(weight_valid, 0, "t6_abort_valid");
        for (int i = 0; i < LAT - 1; i++) tick();
        chk(busy, 1, "t6_abort_busy_hold");
        tick();
        chk(busy, 0, "t6_abort_busy_fall");
        model(12'h100, 10, 1'b0);
        chk(out_q.size(), 3, "t6_abort_count");
        for (int i = 0; i < 3 && i < out_q.size(); i++)
            chk(out_q[i], exp_q[i], $sformatf("t6_abort_w%0d", i));
        chk(last_cnt, 0, "t6_abort_no_last");
        repeat (3) tick();
        clear();
        send(12'h200, 6, 1'b1);
        wait_idle(100, 0);
        model(12'h200, 6, 1'b1);
        compare("t6_next", 6);

        // randomized bursts with random backpressure
        overflow = 0; stall_err = 0;
        for (int r = 0; r < 6; r++) begin
            rb = AW'($urandom);
            rl = $urandom_range(1, 24);
            rm = 1'($urandom_range(0, 1));
            clear();
            send(rb, rl, rm);
            wait_idle(400, 2);
            model(rb, rl, rm);
            compare($sformatf("rnd%0d", r), rl);
            chk(last_cnt, 1, $sformatf("rnd%0d_last", r));
        end
        chk(overflow, 0, "rnd_overflow");
        chk(stall_err, 0, "rnd_stall_stable");

        // reset mid-burst, with abort and cmd_valid asserted under reset
        clear();
        weight_ready = 1'b1;
        send(12'h080, 16, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        abort = 1'b1;
        cmd_valid = 1'b1;
        repeat (3) tick();
        abort = 1'b0;
        cmd_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk(cmd_ready, 1, "t1_cmd_ready");
        chk(busy, 0, "t1_busy");
        chk({weight_valid, weight_last, weight_out}, 0, "t1_out_zero");
        chk({bram_A_en, bram_B_en}, 0, "t1_en_zero");
        valid_cnt = 0;
        repeat (6) tick();
        chk(valid_cnt, 0, "t1_no_stale_valid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_weight_fetcher.md
Name: bram_weight_fetcher

Overview:
- Parametrised successor to the weight BRAM read controller. Streams a commanded burst of MAC_NUM-wide weight words from a true-dual-port BRAM to the MAC array.
- Two read modes: port-A-only, or even/odd split across ports A and B.
- Has a command handshake, output valid/ready backpressure, a latency-matched credit FIFO, a last-word flag and abort.
- Sits between the BRAM block design wrapper and the MAC array's weight input.

Parameters:
- MAC_NUM, 256, number of MAC lanes.
- WEIGHT_WIDTH, 5, bits per lane weight; word width W = WEIGHT_WIDTH*MAC_NUM.
- BRAM_ADDRESS_WIDTH, 12, BRAM address width (AW).
- BRAM_LATENCY, 2, cycles from en/addr to valid dout, range 1..4.
- LEN_WIDTH, 13, width of burst length field.
- FIFO_DEPTH, BRAM_LATENCY+2, output buffer depth in words.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high in IDLE only.
- cmd_base_addr  in  AW  first BRAM address.
- cmd_length  in  LEN_WIDTH  words to deliver.
- cmd_mode  in  1  0 = A-only, 1 = A/B split.
- abort  in  1  cancel current burst.
- bram_address_A  out  AW  port A address.
- bram_A_en  out  1  port A read enable.
- weight_from_bram_A  in  W  port A data.
- bram_address_B  out  AW  port B address.
- bram_B_en  out  1  port B read enable.
- weight_from_bram_B  in  W  port B data.
- weight_out  out  W  delivered word.
- weight_valid  out  1  weight_out valid.
- weight_ready  in  1  consumer accepts.
- weight_last  out  1  final word of burst, qualified by weight_valid.
- busy  out  1  not IDLE.

Behaviour:
- Reset, synchronous on rst=1:
  - state=IDLE, all counters and FIFO cleared, tag pipeline cleared.
  - All outputs 0 except cmd_ready=1.
  - rst overrides abort and cmd_valid in the same cycle.
- Command accept when cmd_valid&&cmd_ready:
  - Latch base, length and mode; issue index k=0.
  - If length==0: go to DONE, produce no reads and no output.
  - Otherwise go to ISSUE.
- Address mapping (address arithmetic wraps modulo 2^AW):
  - Mode 0: word k read from port A at base+k.
  - Mode 1: word k read from port A if k[0]==0, else port B, at base+(k>>1).
- Issue rule, ISSUE state:
  - At most one read per cycle, and only if outstanding+fifo_count < FIFO_DEPTH.
  - Asserting en increments k; the unused port's en=0.
  - The address of the idle port holds its last value.
- Tag pipeline: BRAM_LATENCY-stage shift register carrying {valid, port_sel, last}. On tag exit, the selected port's dout is written to the FIFO the same cycle.
- Credits: the issue gating guarantees the FIFO never overflows. Bench asserts: FIFO write while full is a fatal error.
- Output:
  - weight_valid = FIFO non-empty; weight_out/weight_last come from the FIFO head.
  - Pop on valid&&ready.
  - Data held stable while valid&&!ready.
- Back-to-back throughput: with weight_ready tied 1, one word/cycle after the initial BRAM_LATENCY+1 cycle latency from accept to first weight_valid.
- States and transitions:
  - ISSUE -> DRAIN after the last issue (k==length).
  - DRAIN -> DONE when tags and FIFO are empty and the last word has been popped.
  - DONE -> IDLE after 1 cycle; busy=0 and cmd_ready=1 in IDLE.
- Abort, any non-IDLE state:
  - Stop issuing, flush the FIFO immediately (weight_valid=0 next cycle).
  - Mark in-flight tags invalid; their data is discarded.
  - Enter FLUSH for BRAM_LATENCY cycles, then IDLE.
  - weight_last is never emitted for an aborted burst.
  - abort in IDLE is ignored.
- cmd_valid while busy is not accepted (cmd_ready=0); the command must be held by the producer.
- Length max 2^LEN_WIDTH-1. In mode 1, addresses span ceil(length/2) per port.

Decomposition:
- Shared package bram_fetch_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE, FLUSH}
  - MODE_A_ONLY=0, MODE_SPLIT=1
  - tag struct {valid, port_sel, last}
  - function clog2
- One sub-module: weight_sync_fifo, parametrised on width and depth, with synchronous flush, count output, and first-word-fall-through.

Test Plan:
1. rst high 3 cycles mid-burst -> all outputs 0, cmd_ready=1 the cycle after rst falls; no stale weight_valid.
2. Mode 0, base=0x010, length=4, ready=1, BRAM loaded with word=address:
   - A addresses 0x010..0x013 on consecutive cycles.
   - weight_out 0x010..0x013 starting 3 cycles after accept (latency 2).
   - weight_last on the 4th word.
3. Mode 1, base=0x020, length=5, A[i]=0x1000+i, B[i]=0x2000+i:
   - Output order 0x1020, 0x2020, 0x1021, 0x2021, 0x1022.
   - B en asserted exactly 2 times.
4. Mode 0, length=16, weight_ready toggled 1-in-3 cycles:
   - All 16 words in order with none lost or duplicated.
   - FIFO never overflows.
   - weight_out stable while stalled.
5. Mode 0, base=0xFFE, length=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
6. Length=0 -> busy high 1 cycle, no en, no weight_valid. Then abort after 3 of 10 words delivered -> weight_valid low next cycle, busy falls after BRAM_LATENCY+1 cycles, and the next command delivers its own data only.
